// File: rtl/boot_loader_pkg.sv
// Shared types for the VectorSOC boot loader: FSM state encoding and image magic.
package vsoc_boot_pkg;
    typedef enum logic [2:0] {
        ST_HEADER,
        ST_LOAD,
        ST_CHECK,
        ST_HOLD,
        ST_RUN,
        ST_ERROR
    } state_e;

    localparam logic [15:0] MAGIC = 16'h5653;
endpackage

// File: rtl/boot_loader.sv
// Streams a header/payload/checksum image into instruction memory, verifies it,
// then releases the core from reset after a short hold.
module boot_loader
    import vsoc_boot_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int HOLD_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_resetn,
    output logic              done,
    output logic              error
);
    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0] HC_LAST = (HOLD_CYCLES > 0) ? HC_W'(HOLD_CYCLES - 1) : '0;
    localparam longint unsigned MAX_N = 64'd1 << ADDR_W;

    state_e            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_last;
    logic [DATA_W-1:0] r_sum;
    logic [HC_W-1:0]   r_hold;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_core_resetn;
    logic              r_done;
    logic              r_error;

    logic              w_xfer;
    logic [15:0]       w_hdr_len;
    logic              w_hdr_bad;

    // Ready is a pure state decode so upstream never sees a combinational loop.
    assign s_ready   = (r_state == ST_HEADER) || (r_state == ST_LOAD) || (r_state == ST_CHECK);
    assign w_xfer    = s_valid && s_ready;
    assign w_hdr_len = s_data[15:0];
    assign w_hdr_bad = (s_data[31:16] != MAGIC) || (64'(w_hdr_len) > MAX_N);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_HEADER;
            r_idx         <= '0;
            r_last        <= '0;
            r_sum         <= '0;
            r_hold        <= '0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_core_resetn <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                ST_HEADER: begin
                    if (w_xfer) begin
                        if (w_hdr_bad) begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end else begin
                            r_sum  <= '0;
                            r_idx  <= '0;
                            // N <= 2^ADDR_W here, so N-1 always fits the address width.
                            r_last <= ADDR_W'(w_hdr_len - 16'd1);
                            r_state <= (w_hdr_len == 16'd0) ? ST_CHECK : ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_xfer) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_idx;
                        r_mem_wdata <= s_data;
                        r_sum       <= r_sum + s_data;
                        r_idx       <= r_idx + ADDR_W'(1);
                        if (r_idx == r_last) r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_xfer) begin
                        if (s_data != r_sum) begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end else if (HOLD_CYCLES == 0) begin
                            r_state       <= ST_RUN;
                            r_core_resetn <= 1'b1;
                            r_done        <= 1'b1;
                        end else begin
                            r_state <= ST_HOLD;
                            r_hold  <= '0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_hold == HC_LAST) begin
                        r_state       <= ST_RUN;
                        r_core_resetn <= 1'b1;
                        r_done        <= 1'b1;
                    end else begin
                        r_hold <= r_hold + HC_W'(1);
                    end
                end
                ST_RUN, ST_ERROR: r_state <= r_state;
                default: r_state <= ST_HEADER;
            endcase
        end
    end

    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign core_resetn = r_core_resetn;
    assign done        = r_done;
    assign error       = r_error;
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: image-position model checked every cycle plus literal pins.
module tb_boot_loader;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int HOLD   = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              core_resetn;
    logic              done;
    logic              error;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_resetn(core_resetn), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: tracks position within the image (words consumed) rather than an FSM.
    int              m_cons, m_n, m_since;
    logic [31:0]     m_sum;
    bit              m_bad, m_ok, m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]     m_data;

    always @(posedge clk) begin : model
        bit rdy;
        if (reset) begin
            m_cons = 0; m_n = 0; m_since = 0; m_sum = 0;
            m_bad = 0; m_ok = 0; m_we = 0; m_addr = '0; m_data = '0;
        end else begin
            rdy  = !m_bad && !m_ok;
            m_we = 0;
            if (m_ok) m_since++;
            if (s_valid && rdy) begin
                if (m_cons == 0) begin
                    if (s_data[31:16] != 16'h5653 || int'(s_data[15:0]) > (1 << ADDR_W)) m_bad = 1;
                    else begin m_n = int'(s_data[15:0]); m_sum = 0; m_cons = 1; end
                end else if (m_cons <= m_n) begin
                    m_we = 1; m_addr = ADDR_W'(m_cons - 1); m_data = s_data;
                    m_sum = m_sum + s_data; m_cons++;
                end else if (s_data == m_sum) begin
                    m_ok = 1; m_since = 0;
                end else begin
                    m_bad = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_ready",     32'(s_ready),     32'(!m_bad && !m_ok));
            chk("mem_we",      32'(mem_we),      32'(m_we));
            chk("mem_addr",    32'(mem_addr),    32'(m_addr));
            chk("mem_wdata",   mem_wdata,        m_data);
            chk("core_resetn", 32'(core_resetn), 32'(m_ok && m_since >= HOLD));
            chk("done",        32'(done),        32'(m_ok && m_since >= HOLD));
            chk("error",       32'(error),       32'(m_bad));
        end
    end

    logic [ADDR_W-1:0] wq_addr[$];
    logic [31:0]       wq_data[$];
    always @(negedge clk) if (mem_we) begin
        wq_addr.push_back(mem_addr);
        wq_data.push_back(mem_wdata);
    end

    task automatic push(input logic [31:0] w, input int gap);
        int t = 0;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) begin
            checks++; errors++;
            $display("FAIL push_timeout word %h never accepted", w);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(s_ready), 32'd1);
        chk({tag, "_we"},    32'(mem_we), 32'd0);
        chk({tag, "_addr"},  32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_coren"}, 32'(core_resetn), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        chk_reset_vals("rst0");

        // Good 3-word image, checksum back-to-back with the last payload word.
        push(32'h5653_0003, 0);
        push(32'd1, 0); push(32'd2, 0); push(32'd3, 0);
        push(32'd6, 0);
        chk("good_hold0", 32'(core_resetn), 32'd0);
        repeat (2) @(negedge clk);
        chk("good_hold2", 32'(core_resetn), 32'd0);
        @(negedge clk);
        chk("good_run_coren", 32'(core_resetn), 32'd1);
        chk("good_done", 32'(done), 32'd1);
        chk("good_err", 32'(error), 32'd0);
        chk("good_ready", 32'(s_ready), 32'd0);
        #1;
        chk("good_nwr", 32'(wq_addr.size()), 32'd3);
        for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
            chk("good_waddr", 32'(wq_addr[i]), 32'(i));
            chk("good_wdata", wq_data[i], 32'(i + 1));
        end

        // Bad magic.
        do_reset();
        push(32'h1234_0001, 0);
        chk("magic_err", 32'(error), 32'd1);
        chk("magic_ready", 32'(s_ready), 32'd0);
        chk("magic_coren", 32'(core_resetn), 32'd0);
        repeat (2) @(negedge clk);
        #1 chk("magic_nwr", 32'(wq_addr.size()), 32'd0);

        // Length one past the address space.
        do_reset();
        push(32'h5653_0401, 0);
        chk("oversize_err", 32'(error), 32'd1);

        // Bad checksum.
        do_reset();
        push(32'h5653_0002, 1);
        push(32'd5, 0); push(32'd7, 2);
        push(32'd11, 0);
        chk("badsum_err", 32'(error), 32'd1);
        repeat (5) @(negedge clk);
        chk("badsum_done", 32'(done), 32'd0);
        chk("badsum_err_sticky", 32'(error), 32'd1);

        // Empty image.
        do_reset();
        push(32'h5653_0000, 0);
        push(32'd0, 0);
        repeat (3) @(negedge clk);
        chk("empty_done", 32'(done), 32'd1);
        #1 chk("empty_nwr", 32'(wq_addr.size()), 32'd0);

        // 16 all-ones words with random gaps: sum wraps to 0xFFFF_FFF0.
        do_reset();
        push(32'h5653_0010, 0);
        for (int i = 0; i < 16; i++) push(32'hFFFF_FFFF, $urandom_range(0, 3));
        push(32'hFFFF_FFF0, $urandom_range(0, 2));
        repeat (4) @(negedge clk);
        chk("wrap_done", 32'(done), 32'd1);
        chk("wrap_err", 32'(error), 32'd0);
        #1;
        chk("wrap_nwr", 32'(wq_addr.size()), 32'd16);
        for (int i = 0; i < 16 && i < wq_addr.size(); i++)
            chk("wrap_waddr", 32'(wq_addr[i]), 32'(i));

        // Reset after 2 of 4 payload words, then a fresh image.
        do_reset();
        push(32'h5653_0004, 0);
        push(32'hA0, 0); push(32'hA1, 0);
        do_reset();
        chk_reset_vals("midrst");
        push(32'h5653_0003, 0);
        push(32'd10, 0); push(32'd20, 1); push(32'd30, 0);
        push(32'd60, 0);
        repeat (3) @(negedge clk);
        chk("reload_done", 32'(done), 32'd1);
        #1;
        chk("reload_nwr", 32'(wq_addr.size()), 32'd3);
        for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
            chk("reload_waddr", 32'(wq_addr[i]), 32'(i));
            chk("reload_wdata", wq_data[i], 32'((i + 1) * 10));
        end

        // Reset out of RUN.
        do_reset();
        chk_reset_vals("runrst");

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the instruction-memory write port.
REQ-002 Parameter DATA_W, default 32, stream and memory word width.
REQ-003 Parameter HOLD_CYCLES, default 3, number of cycles core_resetn stays low after a good checksum.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 s_valid  input  1  upstream stream word valid.
REQ-007 s_ready  output  1  loader accepts the stream word this cycle.
REQ-008 s_data  input  DATA_W  stream word.
REQ-009 mem_we  output  1  instruction-memory write strobe.
REQ-010 mem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 mem_wdata  output  DATA_W  instruction-memory write data.
REQ-012 core_resetn  output  1  active-low reset to VectorSOC; low until the image is loaded and verified.
REQ-013 done  output  1  image accepted, core running.
REQ-014 error  output  1  sticky load failure.

Function
REQ-015 A transfer occurs on a cycle with s_valid=1 and s_ready=1.
REQ-016 Image format: one header word, then N payload words, then one checksum word.
- Header bits [31:16] must equal MAGIC 16'h5653.
- Header bits [15:0] are N.
REQ-017 FSM states: HEADER, LOAD, CHECK, HOLD, RUN, ERROR.
REQ-018 HEADER: s_ready=1.
- Header transfer with bad magic -> ERROR.
- N > 2^ADDR_W -> ERROR.
- N=0 -> CHECK.
- Otherwise -> LOAD.
REQ-019 LOAD: s_ready=1.
- Payload word k (k=0..N-1) drives mem_we=1, mem_addr=k, mem_wdata=word exactly one cycle after its transfer.
- After word N-1 -> CHECK.
REQ-020 Checksum: the running sum of payload words modulo 2^DATA_W, cleared on header acceptance.
REQ-021 CHECK: s_ready=1.
- Transfer equal to the sum -> HOLD.
- Any other value -> ERROR.
REQ-022 HOLD: s_ready=0, core_resetn=0 for exactly HOLD_CYCLES cycles, then -> RUN.
REQ-023 RUN: s_ready=0, core_resetn=1, done=1; the FSM stays in RUN until reset.
REQ-024 ERROR: s_ready=0, core_resetn=0, error=1; the FSM stays in ERROR until reset.
REQ-025 s_ready depends only on state, never combinationally on s_valid.
REQ-026 Stalls (s_valid=0) in any accepting state leave the address, sum and state unchanged.
REQ-027 mem_we is 0 in every cycle not following a payload transfer.
REQ-028 The final payload write and the checksum transfer may occur on the same cycle; both take effect.

Reset
REQ-029 Reset values:
- State HEADER.
- s_ready=1, mem_we=0, mem_addr=0, mem_wdata=0.
- core_resetn=0, done=0, error=0.
- Sum=0, counters=0.
REQ-030 Reset asserted mid-load, in HOLD, RUN or ERROR returns the loader to the REQ-029 values on the next edge.
- Partially written memory is not cleared.
- The next header restarts at address 0.

Structure
REQ-031 Package vsoc_boot_pkg holds the state enum type and the MAGIC constant.
REQ-032 Single module; no sub-module. The sum accumulator and the counters stay inline.

Verification
REQ-033 Good image, header 32'h5653_0003, words 1, 2, 3, checksum 6 -> writes:
- addr 0/1/2 with data 1/2/3, each one cycle after its transfer.
- core_resetn stays low 3 cycles after the checksum, then 1.
- done=1, error=0.
REQ-034 Bad magic, header 32'h1234_0001 -> error=1 next cycle, s_ready=0, no mem_we, core_resetn=0.
REQ-035 Bad checksum, header 32'h5653_0002, words 5 and 7, checksum 11 -> ERROR after the checksum transfer, done=0.
REQ-036 Empty image, header 32'h5653_0000, checksum 0 -> no mem_we; RUN after 3 HOLD cycles.
REQ-037 Random s_valid gaps with N=16 and payload 0xFFFF_FFFF -> sum wraps.
- Checksum 0xFFFF_FFF0 -> accepted.
- All 16 writes in order with contiguous addresses.
REQ-038 Reset asserted after 2 of 4 payload words -> all outputs at reset values next cycle; a fresh good image then loads correctly from addr 0.
